unit_serial_add_ctrl: RTL and testbench

UNIT_SERIAL_ADD_CTRL -- requirements
Module: unit_serial_add_ctrl

---
 rtl/unit_serial_add_ctrl_pkg.sv | 27 ++
 rtl/carry_select_adder.sv | 29 ++
 rtl/unit_serial_add_ctrl.sv | 160 ++++++++++++++++
 tb/tb_unit_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/unit_serial_add_ctrl_pkg.sv
// Shared definitions for the serial slice adder controller.
//   SLICE_W : width of one adder slice (the shared adder width)
//   state_e : controller FSM states IDLE / RUN / DONE
//   clog2() : index width helper, never returns less than 1
package unit_serial_add_ctrl_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to index 'value' entries; a one-entry space still gets one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = 32'(i + 1);
            end
        end
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 16-bit carry-select adder: the low byte ripples, the high byte is computed
// for both carry-in values and selected by the low-byte carry.
// Ports:
//   a, b : 16-bit addends
//   cin  : carry-in
//   sum  : 16-bit sum (combinational)
//   cout : carry-out (combinational)
module carry_select_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    // Both high-byte candidates are formed in parallel with the low byte.
    always_comb begin
        lo   = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + 9'(cin);
        hi0  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1  = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
        sum  = lo[8] ? {hi1[7:0], lo[7:0]} : {hi0[7:0], lo[7:0]};
        cout = lo[8] ? hi1[8] : hi0[8];
    end

endmodule

// File: rtl/unit_serial_add_ctrl.sv
// Serial multi-word adder: one shared 16-bit carry-select adder processes one
// slice per cycle, LSB slice first, carrying between slices in a register.
// Optional feature macro: SUBTRACT_EN adds the 'op' port (1 = A-B, 0 = A+B).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   a, b, cin            : operands and carry-in, latched on acceptance
//   op                   : subtract select (SUBTRACT_EN builds only)
//   sum, cout, ovf       : registered result, final carry, signed overflow
//   out_valid / out_ready: result handshake
//   busy                 : high while a request is in RUN or DONE
module unit_serial_add_ctrl
    import unit_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                     cin,
`ifdef SUBTRACT_EN
    input  logic                     op,
`endif
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int unsigned K_W = clog2(WORDS);

    typedef logic [WORDS-1:0][SLICE_W-1:0] slices_t;

    state_e        state_q, state_d;
    slices_t       a_q, a_d;
    slices_t       b_q, b_d;
    slices_t       sum_q, sum_d;
    logic [K_W-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic [SLICE_W-1:0] add_sum;
    logic               add_cout;
    logic               last_slice;

    // Shared datapath: slice k of the latched operands plus the running carry.
    carry_select_adder u_adder (
        .a    (a_q[k_q]),
        .b    (b_q[k_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_slice = (k_q == K_W'(WORDS - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        k_d         = k_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    k_d     = '0;
                    state_d = RUN;
`ifdef SUBTRACT_EN
                    // Subtraction is A + ~B + 1; cin is ignored.
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                sum_d[k_q] = add_sum;
                carry_d    = add_cout;
                if (last_slice) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = add_cout;
                    // Overflow uses the effective (possibly inverted) B sign.
                    ovf_d       = (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1]) &&
                                  (add_sum[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_unit_serial_add_ctrl.sv
// Bench for unit_serial_add_ctrl (WORDS=4): directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (wide arithmetic plus a cycle countdown).
module tb_unit_serial_add_ctrl;

    localparam int unsigned WORDS = 4;
    localparam int unsigned DW    = 16 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          op;
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    unit_serial_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUBTRACT_EN
        .op        (op),
`endif
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_init  = 1'b0;
    bit            m_busy  = 1'b0;
    bit            m_done  = 1'b0;
    bit            m_clean = 1'b0;
    int            m_cnt   = 0;
    logic [DW-1:0] e_sum   = '0;
    logic          e_cout  = 1'b0;
    logic          e_ovf   = 1'b0;

    always @(posedge clk) begin
        logic [DW:0]   full;
        logic [DW-1:0] beff;
        logic          c;
        if (!rst_n) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_clean = 1'b1;
            m_cnt   = 0;
        end else if (m_init) begin
            if (!m_busy) begin
                if (in_valid) begin
                    beff = b;
                    c    = cin;
`ifdef SUBTRACT_EN
                    if (op) begin
                        beff = ~b;
                        c    = 1'b1;
                    end
`endif
                    full    = {1'b0, a} + {1'b0, beff} + (DW + 1)'(c);
                    e_sum   = full[DW-1:0];
                    e_cout  = full[DW];
                    e_ovf   = (a[DW-1] == beff[DW-1]) && (full[DW-1] != a[DW-1]);
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    m_clean = 1'b0;
                end
            end else if (!m_done) begin
                m_cnt++;
                if (m_cnt == WORDS) m_done = 1'b1;
            end else if (out_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready", DW'(in_ready), DW'(!m_busy));
            check("busy", DW'(busy), DW'(m_busy));
            check("out_valid", DW'(out_valid), DW'(m_done));
            if (m_done) begin
                check("sum", sum, e_sum);
                check("cout", DW'(cout), DW'(e_cout));
                check("ovf", DW'(ovf), DW'(e_ovf));
            end
            if (m_clean) begin
                check("sum_after_reset", sum, '0);
                check("cout_after_reset", DW'(cout), '0);
                check("ovf_after_reset", DW'(ovf), '0);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Called at a negedge with the DUT idle: issue one request, wait for the
    // result with a bounded wait, check literals, then consume it.
    task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic tcin,
                          input logic top, input logic [DW-1:0] xs, input logic xc, input logic xo,
                          input string name);
        int j;
        a = ta; b = tb_; cin = tcin; op = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        j = 0;
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        check({name, "_latency"}, DW'(j), DW'(WORDS));
        check({name, "_sum"}, sum, xs);
        check({name, "_cout"}, DW'(cout), DW'(xc));
        check({name, "_ovf"}, DW'(ovf), DW'(xo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_in_ready_after"}, DW'(in_ready), DW'(1));
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        int j;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", DW'(in_ready), DW'(1));
        check("reset_busy", DW'(busy), '0);
        check("reset_out_valid", DW'(out_valid), '0);
        check("reset_sum", sum, '0);

        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "carry_slice1");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, "full_ripple");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "pos_ovf");
`ifdef SUBTRACT_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_op(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, "sub_pos");
`endif

        // Back-pressure: result must hold while new requests are ignored.
        a = 64'd1; b = 64'd2; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        j = 0;
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        check("stall_latency", DW'(j), DW'(WORDS));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = {$urandom(), $urandom()};
            @(negedge clk);
            check("stall_sum", sum, 64'd3);
            check("stall_in_ready", DW'(in_ready), '0);
            check("stall_out_valid", DW'(out_valid), DW'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release_in_ready", DW'(in_ready), DW'(1));
        check("stall_release_busy", DW'(busy), '0);

        // Reset while the third slice is being processed.
        a = '1; b = '0; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_out_valid", DW'(out_valid), '0);
        check("midrun_reset_sum", sum, '0);
        check("midrun_reset_in_ready", DW'(in_ready), DW'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrun_reset_no_result", DW'(out_valid), '0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = rand_operand();
            b         = rand_operand();
            cin       = 1'($urandom_range(0, 1));
            op        = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
